// File: rtl/bonus_pkg.sv
// Shared constants for the bonus/bomb slot pool: slot state encoding, default
// sizing and object type codes.
package bonus_pkg;

    typedef logic [1:0] slot_state_t;

    localparam slot_state_t IDLE   = 2'd0;
    localparam slot_state_t ACTIVE = 2'd1;
    localparam slot_state_t FADING = 2'd2;

    localparam int unsigned BONUS_NUM         = 4;
    localparam int unsigned BONUS_IDX_W       = 2;
    localparam int unsigned BONUS_TYPE_W      = 2;
    localparam int unsigned BONUS_LIFE_FRAMES = 600;
    localparam int unsigned BONUS_FADE_FRAMES = 120;
    localparam int unsigned BONUS_BLINK_SHIFT = 3;
    localparam int unsigned BONUS_RGB_W       = 12;

    localparam int unsigned BONUS_TYPE_BOMB = 0;
    localparam int unsigned BONUS_TYPE_FIRE = 1;
    localparam int unsigned BONUS_TYPE_LIFE = 2;

endpackage

// File: rtl/bonus_pool_if.sv
// Bundle between enemy_base/compositor/score logic (master) and bonus_pool (slave).
interface bonus_pool_if
    import bonus_pkg::*;
#(
    parameter int unsigned NUM    = BONUS_NUM,
    parameter int unsigned IDX_W  = BONUS_IDX_W,
    parameter int unsigned TYPE_W = BONUS_TYPE_W,
    parameter int unsigned RGB_W  = BONUS_RGB_W
);
    logic                    v_sync_i;
    logic                    trigger_i;
    logic [IDX_W-1:0]        trigger_idx_i;
    logic [TYPE_W-1:0]       trigger_type_i;
    logic                    crash_i;
    logic [IDX_W-1:0]        curr_idx_i;
    logic                    obj_vali_i;
    logic                    bram_alpha_i;
    logic [RGB_W-1:0]        bram_rgb_i;
    logic [NUM-1:0]          disappear_o;
    logic [NUM*TYPE_W-1:0]   slot_type_o;
    logic                    collect_o;
    logic [TYPE_W-1:0]       collect_type_o;
    logic                    expire_o;
    logic [IDX_W:0]          active_cnt_o;
    logic                    vga_alpha_o;
    logic [RGB_W-1:0]        vga_rgb_o;

    modport master (
        output v_sync_i, trigger_i, trigger_idx_i, trigger_type_i, crash_i,
               curr_idx_i, obj_vali_i, bram_alpha_i, bram_rgb_i,
        input  disappear_o, slot_type_o, collect_o, collect_type_o, expire_o,
               active_cnt_o, vga_alpha_o, vga_rgb_o
    );

    modport slave (
        input  v_sync_i, trigger_i, trigger_idx_i, trigger_type_i, crash_i,
               curr_idx_i, obj_vali_i, bram_alpha_i, bram_rgb_i,
        output disappear_o, slot_type_o, collect_o, collect_type_o, expire_o,
               active_cnt_o, vga_alpha_o, vga_rgb_o
    );
endinterface

// File: rtl/bonus_slot.sv
// One pool slot: IDLE/ACTIVE/FADING FSM with a frame-counted life and a type register.
module bonus_slot
    import bonus_pkg::*;
#(
    parameter int unsigned TYPE_W      = BONUS_TYPE_W,
    parameter int unsigned LIFE_FRAMES = BONUS_LIFE_FRAMES,
    parameter int unsigned FADE_FRAMES = BONUS_FADE_FRAMES,
    parameter int unsigned BLINK_SHIFT = BONUS_BLINK_SHIFT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_i,
    input  logic              trig_i,
    input  logic [TYPE_W-1:0] trig_type_i,
    input  logic              crash_i,
    output logic              idle_o,
    output logic              render_en_c,
    output logic              collect_c,
    output logic              expire_c,
    output logic [TYPE_W-1:0] type_o
);
    localparam int unsigned LIFE_W = $clog2(LIFE_FRAMES + 1);

    slot_state_t       state_q, state_d;
    logic [LIFE_W-1:0] life_q, life_d;
    logic [TYPE_W-1:0] type_q, type_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            life_q  <= '0;
            type_q  <= '0;
        end else begin
            state_q <= state_d;
            life_q  <= life_d;
            type_q  <= type_d;
        end
    end

    // Crash takes priority over the frame tick in both live states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trig_i) state_d = ACTIVE;
            ACTIVE: begin
                if (crash_i) state_d = IDLE;
                else if (tick_i && life_q == LIFE_W'(FADE_FRAMES + 1)) state_d = FADING;
            end
            FADING: begin
                if (crash_i) state_d = IDLE;
                else if (tick_i && life_q == LIFE_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        life_d      = life_q;
        type_d      = type_q;
        collect_c   = 1'b0;
        expire_c    = 1'b0;
        render_en_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_i) begin
                    life_d = LIFE_W'(LIFE_FRAMES);
                    type_d = trig_type_i;
                end
            end
            ACTIVE: begin
                render_en_c = 1'b1;
                if (crash_i) begin
                    life_d    = '0;
                    collect_c = 1'b1;
                end else if (tick_i) begin
                    life_d = life_q - LIFE_W'(1);
                end
            end
            FADING: begin
                render_en_c = ~life_q[BLINK_SHIFT];
                if (crash_i) begin
                    life_d    = '0;
                    collect_c = 1'b1;
                end else if (tick_i) begin
                    life_d   = life_q - LIFE_W'(1);
                    expire_c = (life_q == LIFE_W'(1));
                end
            end
            default: life_d = '0;
        endcase
    end

    assign idle_o = (state_q == IDLE);
    assign type_o = type_q;

endmodule

// File: rtl/bonus_pool.sv
// Slot manager for falling bombs/bonuses: frame tick, per-slot FSMs, event pulses,
// active popcount and sprite pixel gating.
module bonus_pool
    import bonus_pkg::*;
#(
    parameter int unsigned NUM         = BONUS_NUM,
    parameter int unsigned IDX_W       = BONUS_IDX_W,
    parameter int unsigned TYPE_W      = BONUS_TYPE_W,
    parameter int unsigned LIFE_FRAMES = BONUS_LIFE_FRAMES,
    parameter int unsigned FADE_FRAMES = BONUS_FADE_FRAMES,
    parameter int unsigned BLINK_SHIFT = BONUS_BLINK_SHIFT,
    parameter int unsigned RGB_W       = BONUS_RGB_W
) (
    input logic         clk_vga,
    input logic         rst,
    bonus_pool_if.slave bus
);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic              v_sync_q, v_sync_d;
    logic              collect_q, collect_d;
    logic              expire_q, expire_d;
    logic [TYPE_W-1:0] collect_type_q, collect_type_d;
    logic              tick;

    logic [NUM-1:0]        idle;
    logic [NUM-1:0]        render_en;
    logic [NUM-1:0]        collect_c;
    logic [NUM-1:0]        expire_c;
    logic [TYPE_W-1:0]     slot_type [NUM];
    logic [NUM*TYPE_W-1:0] slot_type_packed;
    logic [TYPE_W-1:0]     sel_type;
    logic                  sel_render;
    logic                  pix_en;
    logic [CNT_W-1:0]      active_cnt;

    assign tick = bus.v_sync_i & ~v_sync_q;

    for (genvar i = 0; i < NUM; i++) begin : g_slot
        bonus_slot #(
            .TYPE_W      (TYPE_W),
            .LIFE_FRAMES (LIFE_FRAMES),
            .FADE_FRAMES (FADE_FRAMES),
            .BLINK_SHIFT (BLINK_SHIFT)
        ) u_slot (
            .clk         (clk_vga),
            .rst         (rst),
            .tick_i      (tick),
            .trig_i      (bus.trigger_i && (bus.trigger_idx_i == IDX_W'(i))),
            .trig_type_i (bus.trigger_type_i),
            .crash_i     (bus.crash_i && (bus.curr_idx_i == IDX_W'(i))),
            .idle_o      (idle[i]),
            .render_en_c (render_en[i]),
            .collect_c   (collect_c[i]),
            .expire_c    (expire_c[i]),
            .type_o      (slot_type[i])
        );
    end

    // An out-of-range curr_idx_i matches no slot and therefore reads as idle.
    always_comb begin
        sel_type   = '0;
        sel_render = 1'b0;
        for (int unsigned i = 0; i < NUM; i++) begin
            if (bus.curr_idx_i == IDX_W'(i)) begin
                sel_type   = slot_type[i];
                sel_render = render_en[i];
            end
        end
    end

    always_comb begin
        active_cnt       = '0;
        slot_type_packed = '0;
        for (int unsigned i = 0; i < NUM; i++) begin
            active_cnt = active_cnt + CNT_W'(~idle[i]);
            slot_type_packed[i*TYPE_W +: TYPE_W] = slot_type[i];
        end
    end

    always_comb begin
        v_sync_d       = bus.v_sync_i;
        collect_d      = |collect_c;
        expire_d       = |expire_c;
        collect_type_d = collect_d ? sel_type : collect_type_q;
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            v_sync_q       <= 1'b0;
            collect_q      <= 1'b0;
            expire_q       <= 1'b0;
            collect_type_q <= '0;
        end else begin
            v_sync_q       <= v_sync_d;
            collect_q      <= collect_d;
            expire_q       <= expire_d;
            collect_type_q <= collect_type_d;
        end
    end

    assign pix_en = bus.obj_vali_i & sel_render;

    assign bus.disappear_o    = idle;
    assign bus.slot_type_o    = slot_type_packed;
    assign bus.collect_o      = collect_q;
    assign bus.collect_type_o = collect_type_q;
    assign bus.expire_o       = expire_q;
    assign bus.active_cnt_o   = active_cnt;
    assign bus.vga_alpha_o    = pix_en & bus.bram_alpha_i;
    assign bus.vga_rgb_o      = pix_en ? bus.bram_rgb_i : '0;

endmodule

// File: tb/tb_bonus_pool.sv
// Directed bench for bonus_pool with a scoreboard queue of expected collect/expire pulses.
module tb_bonus_pool;
    import bonus_pkg::*;

    localparam int unsigned NUM    = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned TYPE_W = 2;
    localparam int unsigned RGB_W  = 12;
    localparam int unsigned LIFE   = 10;
    localparam int unsigned FADE   = 4;
    localparam int unsigned BLINK  = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bonus_pool_if #(.NUM(NUM), .IDX_W(IDX_W), .TYPE_W(TYPE_W), .RGB_W(RGB_W)) bus ();

    bonus_pool #(
        .NUM(NUM), .IDX_W(IDX_W), .TYPE_W(TYPE_W), .LIFE_FRAMES(LIFE),
        .FADE_FRAMES(FADE), .BLINK_SHIFT(BLINK), .RGB_W(RGB_W)
    ) dut (
        .clk_vga (clk),
        .rst     (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic              is_exp;
        logic [TYPE_W-1:0] typ;
    } ev_t;

    ev_t exp_q[$];
    int  passed = 0;
    int  total  = 0;
    int  life_m;
    int  rend_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.v_sync_i = 1'b1;
        cyc();
        bus.v_sync_i = 1'b0;
        cyc();
    endtask

    task automatic spawn(input int idx, input int typ);
        bus.trigger_i      = 1'b1;
        bus.trigger_idx_i  = IDX_W'(idx);
        bus.trigger_type_i = TYPE_W'(typ);
        cyc();
        bus.trigger_i = 1'b0;
    endtask

    task automatic push_collect(input int typ);
        ev_t e;
        e.is_exp = 1'b0;
        e.typ    = TYPE_W'(typ);
        exp_q.push_back(e);
    endtask

    task automatic push_expire();
        ev_t e;
        e.is_exp = 1'b1;
        e.typ    = '0;
        exp_q.push_back(e);
    endtask

    // Every collect/expire pulse cycle must match the head of the expected queue.
    always @(negedge clk) begin
        ev_t got;
        ev_t want;
        if (bus.collect_o === 1'b1 || bus.expire_o === 1'b1) begin
            got.is_exp = bus.expire_o;
            got.typ    = bus.expire_o ? '0 : bus.collect_type_o;
            total++;
            assert (exp_q.size() != 0) passed++;
            else $error("FAIL sb_unexpected: observed collect=%b expire=%b expected no event",
                        bus.collect_o, bus.expire_o);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                chk("sb_event", 32'(got), 32'(want));
            end
        end
    end

    initial begin
        bus.v_sync_i       = 1'b0;
        bus.trigger_i      = 1'b0;
        bus.trigger_idx_i  = '0;
        bus.trigger_type_i = '0;
        bus.crash_i        = 1'b0;
        bus.curr_idx_i     = '0;
        bus.obj_vali_i     = 1'b1;
        bus.bram_alpha_i   = 1'b1;
        bus.bram_rgb_i     = 12'hABC;

        // Reset state
        cyc();
        cyc();
        chk("rst_disappear", 32'(bus.disappear_o), 32'hF);
        chk("rst_cnt", 32'(bus.active_cnt_o), 0);
        chk("rst_types", 32'(bus.slot_type_o), 0);
        chk("rst_collect", 32'(bus.collect_o), 0);
        chk("rst_expire", 32'(bus.expire_o), 0);
        chk("rst_alpha", 32'(bus.vga_alpha_o), 0);
        chk("rst_rgb", 32'(bus.vga_rgb_o), 0);
        rst = 1'b0;
        cyc();

        // Spawn slot 2 with type 1
        spawn(2, BONUS_TYPE_FIRE);
        chk("spawn_disappear", 32'(bus.disappear_o), 32'b1011);
        chk("spawn_cnt", 32'(bus.active_cnt_o), 1);
        chk("spawn_type2", 32'(bus.slot_type_o[5:4]), 1);
        bus.curr_idx_i = 2'd2;
        #1;
        chk("pix_alpha_on", 32'(bus.vga_alpha_o), 1);
        chk("pix_rgb_on", 32'(bus.vga_rgb_o), 32'hABC);
        bus.bram_alpha_i = 1'b0;
        #1;
        chk("pix_alpha_transparent", 32'(bus.vga_alpha_o), 0);
        bus.bram_alpha_i = 1'b1;
        bus.obj_vali_i   = 1'b0;
        #1;
        chk("pix_rgb_nohit", 32'(bus.vga_rgb_o), 0);
        bus.obj_vali_i = 1'b1;
        push_collect(BONUS_TYPE_FIRE);
        bus.crash_i = 1'b1;
        cyc();
        bus.crash_i = 1'b0;
        chk("crash2_collect", 32'(bus.collect_o), 1);
        chk("crash2_type", 32'(bus.collect_type_o), 1);
        chk("crash2_disappear", 32'(bus.disappear_o), 32'hF);

        // Full lifetime of slot 0 with blink during fade
        bus.curr_idx_i = 2'd0;
        spawn(0, BONUS_TYPE_BOMB);
        life_m = LIFE;
        for (int f = 1; f <= int'(LIFE); f++) begin
            if (life_m == 1) push_expire();
            frame();
            life_m--;
            if (life_m == 0) rend_m = 0;
            else if (life_m > int'(FADE)) rend_m = 1;
            else rend_m = (((life_m >> BLINK) & 1) == 0) ? 1 : 0;
            chk($sformatf("life_disappear_f%0d", f), 32'(bus.disappear_o[0]), (life_m == 0) ? 1 : 0);
            chk($sformatf("life_render_f%0d", f), 32'(bus.vga_alpha_o), 32'(rend_m));
        end

        // Collect slot 1, then a repeated crash on the now idle slot
        spawn(1, BONUS_TYPE_LIFE);
        chk("slot1_type", 32'(bus.slot_type_o[3:2]), 2);
        bus.curr_idx_i = 2'd1;
        push_collect(BONUS_TYPE_LIFE);
        bus.crash_i = 1'b1;
        cyc();
        bus.crash_i = 1'b0;
        chk("crash1_type", 32'(bus.collect_type_o), 2);
        chk("crash1_disappear", 32'(bus.disappear_o[1]), 1);
        bus.crash_i = 1'b1;
        cyc();
        bus.crash_i = 1'b0;
        chk("crash1_repeat", 32'(bus.collect_o), 0);

        // Crash coinciding with the final tick of slot 3
        spawn(3, BONUS_TYPE_FIRE);
        for (int f = 0; f < int'(LIFE) - 1; f++) frame();
        chk("slot3_alive", 32'(bus.disappear_o[3]), 0);
        push_collect(BONUS_TYPE_FIRE);
        bus.curr_idx_i = 2'd3;
        bus.crash_i    = 1'b1;
        bus.v_sync_i   = 1'b1;
        cyc();
        bus.crash_i  = 1'b0;
        bus.v_sync_i = 1'b0;
        chk("race_collect", 32'(bus.collect_o), 1);
        chk("race_expire", 32'(bus.expire_o), 0);
        chk("race_disappear", 32'(bus.disappear_o[3]), 1);
        cyc();

        // Retrigger of an active slot keeps its type and remaining life
        spawn(1, BONUS_TYPE_LIFE);
        frame();
        frame();
        spawn(1, 3);
        chk("retrig_type", 32'(bus.slot_type_o[3:2]), 2);
        for (int f = 0; f < int'(LIFE) - 3; f++) frame();
        chk("retrig_alive", 32'(bus.disappear_o[1]), 0);
        push_expire();
        frame();
        chk("retrig_expired", 32'(bus.disappear_o[1]), 1);

        // Trigger and crash on the same idle slot: trigger wins
        bus.curr_idx_i     = 2'd0;
        bus.crash_i        = 1'b1;
        bus.trigger_i      = 1'b1;
        bus.trigger_idx_i  = 2'd0;
        bus.trigger_type_i = 2'd2;
        cyc();
        bus.crash_i   = 1'b0;
        bus.trigger_i = 1'b0;
        chk("trigcrash_active", 32'(bus.disappear_o[0]), 0);
        chk("trigcrash_nocollect", 32'(bus.collect_o), 0);
        chk("trigcrash_type", 32'(bus.slot_type_o[1:0]), 2);

        // Reset in the middle of fading with all slots live
        spawn(1, 1);
        spawn(2, 2);
        spawn(3, 3);
        for (int f = 0; f < int'(LIFE - FADE); f++) frame();
        chk("full_cnt", 32'(bus.active_cnt_o), 4);
        chk("fade_render_on", 32'(bus.vga_alpha_o), 1);
        rst          = 1'b1;
        bus.v_sync_i = 1'b1;
        cyc();
        chk("mid_rst_disappear", 32'(bus.disappear_o), 32'hF);
        chk("mid_rst_cnt", 32'(bus.active_cnt_o), 0);
        chk("mid_rst_types", 32'(bus.slot_type_o), 0);
        chk("mid_rst_collect_type", 32'(bus.collect_type_o), 0);
        chk("mid_rst_collect", 32'(bus.collect_o), 0);
        chk("mid_rst_expire", 32'(bus.expire_o), 0);
        chk("mid_rst_alpha", 32'(bus.vga_alpha_o), 0);
        chk("mid_rst_rgb", 32'(bus.vga_rgb_o), 0);
        rst = 1'b0;
        cyc();
        bus.v_sync_i = 1'b0;
        cyc();
        chk("post_rst_idle", 32'(bus.disappear_o), 32'hF);

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
